lcd_char_ctrl: RTL and testbench

- Parametrised HD44780-class character-LCD controller; successor to the serial-byte-to-LCD bridge.
- Accepts an escaped byte stream via valid/ready, typically from async_receiver; buffers it in a FIFO.
- Runs a power-on init sequence, then emits each byte as an instruction or data write.
- Generates setup, E-pulse, hold and execution-time waits in 8-bit or 4-bit bus mode.
- Sits between the UART receiver and the LCD pins.

---
 rtl/lcd_char_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_lcd_char_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: escaped byte stream to an HD44780-class character LCD.
// FIFO-buffered input, power-on init ROM, 8- or 4-bit bus write timing.
module lcd_char_ctrl #(
  parameter int         BUS_BITS         = 8,
  parameter int         FIFO_DEPTH       = 16,
  parameter logic [7:0] ESC_CODE         = 8'h00,
  parameter int         SETUP_CYCLES     = 2,
  parameter int         E_CYCLES         = 6,
  parameter int         HOLD_CYCLES      = 1,
  parameter int         EXEC_CYCLES      = 1000,
  parameter int         LONG_EXEC_CYCLES = 40000,
  parameter int         POWERON_CYCLES   = 375000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       overflow,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(
    max2(max2(SETUP_CYCLES, E_CYCLES), max2(HOLD_CYCLES, EXEC_CYCLES)),
    max2(LONG_EXEC_CYCLES, POWERON_CYCLES));
  localparam int CW  = $clog2(MAXC + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam bit NIB = (BUS_BITS == 4);

  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] E_L     = CW'(E_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] EXEC_L  = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] LONG_L  = CW'(LONG_EXEC_CYCLES - 1);
  localparam logic [CW-1:0] PON_L   = CW'(POWERON_CYCLES - 1);
  localparam logic [2:0]    INIT_LAST = NIB ? 3'd7 : 3'd6;

  typedef enum logic [2:0] {
    S_POWERON, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic        empty, full, push, pop, esc_pending;
  logic [8:0]  rd;

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready
                 && (esc_pending || (in_data != ESC_CODE));
  assign rd       = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= {!esc_pending, in_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp          <= '0;
      rp          <= '0;
      esc_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (in_valid && in_ready)
        esc_pending <= !esc_pending && (in_data == ESC_CODE);
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  function automatic logic is_long(logic rs, logic [7:0] b);
    return !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
  endfunction

  function automatic logic [7:0] hi_bus(logic [7:0] b);
    return NIB ? {b[7:4], 4'h0} : b;
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    step, step_n;
  logic          nib, nib_n, single_q, single_n, long_q, long_n;
  logic          done_n, rs_n;
  logic [3:0]    lo_q, lo_n;
  logic [7:0]    db_n, rom_b;
  logic          rom_s;

  // 4-bit single-nibble steps keep the nibble in [7:4] so 0x2 stays short
  always_comb begin
    rom_b = 8'h06;
    rom_s = 1'b0;
    if (NIB) begin
      unique case (step)
        3'd0, 3'd1, 3'd2: begin rom_b = 8'h30; rom_s = 1'b1; end
        3'd3:    begin rom_b = 8'h20; rom_s = 1'b1; end
        3'd4:    rom_b = 8'h28;
        3'd5:    rom_b = 8'h0C;
        3'd6:    rom_b = 8'h01;
        default: rom_b = 8'h06;
      endcase
    end else begin
      unique case (step)
        3'd0, 3'd1, 3'd2: rom_b = 8'h30;
        3'd3:    rom_b = 8'h38;
        3'd4:    rom_b = 8'h0C;
        3'd5:    rom_b = 8'h01;
        default: rom_b = 8'h06;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    step_n   = step;
    nib_n    = nib;
    single_n = single_q;
    long_n   = long_q;
    lo_n     = lo_q;
    rs_n     = lcd_rs;
    db_n     = lcd_db;
    done_n   = init_done;
    pop      = 1'b0;
    unique case (state)
      S_POWERON: begin
        cnt_n = cnt + 1'b1;
        if (cnt == PON_L) begin
          cnt_n   = '0;
          state_n = S_INIT;
        end
      end
      S_INIT: begin
        rs_n     = 1'b0;
        db_n     = hi_bus(rom_b);
        lo_n     = rom_b[3:0];
        single_n = rom_s;
        nib_n    = 1'b0;
        long_n   = (step == 3'd0) || is_long(1'b0, rom_b);
        state_n  = S_SETUP;
      end
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          rs_n     = rd[8];
          db_n     = hi_bus(rd[7:0]);
          lo_n     = rd[3:0];
          single_n = 1'b0;
          nib_n    = 1'b0;
          long_n   = is_long(rd[8], rd[7:0]);
          state_n  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == SETUP_L) begin
          cnt_n   = '0;
          state_n = S_PULSE;
        end
      end
      S_PULSE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == E_L) begin
          cnt_n   = '0;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == HOLD_L) begin
          cnt_n   = '0;
          state_n = S_WAIT;
          if (NIB && !single_q && !nib) begin
            nib_n   = 1'b1;
            db_n    = {lo_q, 4'h0};
            state_n = S_SETUP;
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == (long_q ? LONG_L : EXEC_L)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          if (!init_done) begin
            if (step == INIT_LAST) begin
              done_n = 1'b1;
            end else begin
              step_n  = step + 3'd1;
              state_n = S_INIT;
            end
          end
        end
      end
      default: state_n = S_POWERON;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_POWERON;
      cnt       <= '0;
      step      <= '0;
      nib       <= 1'b0;
      single_q  <= 1'b0;
      long_q    <= 1'b0;
      lo_q      <= '0;
      lcd_rs    <= 1'b0;
      lcd_db    <= '0;
      lcd_e     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      nib       <= nib_n;
      single_q  <= single_n;
      long_q    <= long_n;
      lo_q      <= lo_n;
      lcd_rs    <= rs_n;
      lcd_db    <= db_n;
      lcd_e     <= (state_n == S_PULSE);
      init_done <= done_n;
    end
  end

  assign busy   = (state != S_IDLE) || !empty;
  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl: scoreboarded LCD-write checks for the 8-bit and
// 4-bit builds of lcd_char_ctrl with small timing parameters.
module tb_lcd_char_ctrl;

  localparam int S   = 2;
  localparam int E   = 3;
  localparam int H   = 1;
  localparam int EX  = 5;
  localparam int LG  = 20;
  localparam int PON = 10;
  localparam int DEP = 4;
  localparam int INIT8_DONE =
    (PON + 1 + S) + 2 * (1 + S + E + H + LG) + 4 * (1 + S + E + H + EX)
    + (E + H + EX);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rn8 = 1'b0, v8 = 1'b0, rn4 = 1'b0, v4 = 1'b0;
  logic [7:0] d8 = 8'h00, d4 = 8'h00;
  logic       rdy8, ovf8, done8, busy8, rs8, rw8, e8;
  logic       rdy4, ovf4, done4, busy4, rs4, rw4, e4;
  logic [7:0] db8, db4;

  lcd_char_ctrl #(
    .BUS_BITS(8), .FIFO_DEPTH(DEP), .ESC_CODE(8'h00),
    .SETUP_CYCLES(S), .E_CYCLES(E), .HOLD_CYCLES(H),
    .EXEC_CYCLES(EX), .LONG_EXEC_CYCLES(LG), .POWERON_CYCLES(PON)
  ) u8 (
    .clk(clk), .resetn(rn8), .in_data(d8), .in_valid(v8),
    .in_ready(rdy8), .overflow(ovf8), .init_done(done8), .busy(busy8),
    .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8), .lcd_db(db8)
  );

  lcd_char_ctrl #(
    .BUS_BITS(4), .FIFO_DEPTH(DEP), .ESC_CODE(8'h00),
    .SETUP_CYCLES(S), .E_CYCLES(E), .HOLD_CYCLES(H),
    .EXEC_CYCLES(EX), .LONG_EXEC_CYCLES(LG), .POWERON_CYCLES(PON)
  ) u4 (
    .clk(clk), .resetn(rn4), .in_data(d4), .in_valid(v4),
    .in_ready(rdy4), .overflow(ovf4), .init_done(done4), .busy(busy4),
    .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4), .lcd_db(db4)
  );

  logic       sel = 1'b0;
  logic       me, mrs, mrn, mb;
  logic [7:0] mdb;
  assign me  = sel ? e4 : e8;
  assign mrs = sel ? rs4 : rs8;
  assign mdb = sel ? db4 : db8;
  assign mrn = sel ? rn4 : rn8;
  assign mb  = sel ? busy4 : busy8;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         per;
  } wr_t;

  typedef struct {
    logic [7:0] din;
    bit         push;
    logic       rs;
    logic [7:0] db;
  } vec_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  pexec = 0;
  int  last_rise = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // per0: >0 explicit rise-to-rise, 0 = unchecked, <0 = back-to-back
  task automatic exp_byte(input logic rs, input logic [7:0] b,
                          input bit b4, input bit single,
                          input bit first_init, input int per0);
    wr_t w;
    w.rs  = rs;
    w.per = (per0 < 0) ? (1 + S + E + H + pexec) : per0;
    w.db  = b4 ? {b[7:4], 4'h0} : b;
    sb.push_back(w);
    if (b4 && !single) begin
      w.db  = {b[3:0], 4'h0};
      w.per = H + S + E;
      sb.push_back(w);
    end
    pexec = (first_init || (!rs && b >= 8'h01 && b <= 8'h03)) ? LG : EX;
  endtask

  logic       pe;
  logic [8:0] prev_bus;
  int         wid, stab;
  bit         chg;
  wr_t        cur;

  always @(negedge clk) begin
    if (!mrn) begin
      pe        = 1'b0;
      wid       = 0;
      stab      = 0;
      chg       = 1'b0;
      prev_bus  = {mrs, mdb};
      last_rise = cyc;
    end else begin
      if (me) begin
        if (!pe) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got rs=%0d db=%0h, required none",
                     mrs, mdb);
          end else begin
            cur = sb.pop_front();
            chk("write_rs", mrs, cur.rs);
            chk("write_db", mdb, cur.db);
            if (cur.per != 0) chk("write_period", cyc - last_rise, cur.per);
            if (chg) chk("setup_cycles", stab, S);
          end
          last_rise = cyc;
          chg       = 1'b0;
          wid       = 1;
        end else begin
          wid++;
          chk("bus_stable_in_e", {mrs, mdb}, prev_bus);
        end
      end else begin
        if (pe) chk("e_width", wid, E);
        if ({mrs, mdb} != prev_bus) begin
          chg  = 1'b1;
          stab = 1;
        end else begin
          stab++;
        end
      end
      pe       = me;
      prev_bus = {mrs, mdb};
    end
  end

  task automatic drain(input string nm);
    for (int k = 0; k < 2000 && (mb || sb.size() != 0); k++) tick();
    chk({nm, "_drained"}, (!mb && sb.size() == 0), 1);
    chk({nm, "_final_exec"}, cyc - last_rise, E + H + pexec);
  endtask

  logic [7:0] init8 [7];
  logic [7:0] init4 [8];
  vec_t       tv [5];
  int         rel;
  bit         first;

  task automatic exp_init8();
    for (int k = 0; k < 7; k++)
      exp_byte(1'b0, init8[k], 1'b0, 1'b0, k == 0, (k == 0) ? PON + 1 + S : -1);
  endtask

  task automatic wait_done8(input string nm);
    for (int k = 0; k < 500 && !done8; k++) tick();
    chk({nm, "_init_done"}, done8, 1);
    chk({nm, "_init_done_cycle"}, cyc - rel, INIT8_DONE);
  endtask

  initial begin
    init8 = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
    init4 = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h01, 8'h06};
    tv[0] = '{8'h41, 1'b1, 1'b1, 8'h41};
    tv[1] = '{8'h00, 1'b0, 1'b0, 8'h00};
    tv[2] = '{8'h01, 1'b1, 1'b0, 8'h01};
    tv[3] = '{8'h00, 1'b0, 1'b0, 8'h00};
    tv[4] = '{8'h00, 1'b1, 1'b0, 8'h00};

    tick();
    tick();
    chk("rst_ready", rdy8, 1);
    chk("rst_overflow", ovf8, 0);
    chk("rst_init_done", done8, 0);
    chk("rst_e", e8, 0);
    chk("rst_rs", rs8, 0);
    chk("rst_db", db8, 0);
    chk("rst_rw", rw8, 0);
    chk("rst_busy", busy8, 1);

    rn8 = 1'b1;
    rel = cyc;
    exp_init8();
    for (int i = 0; i < 4; i++) begin
      d8 = 8'h61 + 8'(i);
      v8 = 1'b1;
      chk("bp_ready", rdy8, 1);
      exp_byte(1'b1, d8, 1'b0, 1'b0, 1'b0, -1);
      tick();
    end
    chk("bp_full", rdy8, 0);
    chk("bp_no_overflow_yet", ovf8, 0);
    d8 = 8'h65;
    tick();
    v8 = 1'b0;
    chk("bp_overflow", ovf8, 1);
    wait_done8("pwr");
    drain("bp");
    chk("overflow_sticky", ovf8, 1);

    first = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d8 = tv[i].din;
      v8 = 1'b1;
      chk("esc_ready", rdy8, 1);
      if (tv[i].push) begin
        exp_byte(tv[i].rs, tv[i].db, 1'b0, 1'b0, 1'b0, first ? 0 : -1);
        first = 1'b0;
      end
      tick();
    end
    v8 = 1'b0;
    drain("esc");

    d8 = 8'h51;
    v8 = 1'b1;
    exp_byte(1'b1, 8'h51, 1'b0, 1'b0, 1'b0, 0);
    tick();
    d8 = 8'h52;
    exp_byte(1'b1, 8'h52, 1'b0, 1'b0, 1'b0, -1);
    tick();
    v8 = 1'b0;
    chk("pushpop_busy", busy8, 1);
    drain("pushpop");

    for (int i = 0; i < 5; i++) begin
      d8 = 8'h71 + 8'(i);
      v8 = 1'b1;
      if (i == 0) exp_byte(1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 0);
      tick();
    end
    v8 = 1'b0;
    for (int k = 0; k < 50 && !e8; k++) tick();
    chk("mid_e_high", e8, 1);
    chk("mid_fifo_full", rdy8, 0);
    rn8 = 1'b0;
    #1;
    chk("mid_e_drop", e8, 0);
    chk("mid_fifo_flushed", rdy8, 1);
    chk("mid_overflow_clr", ovf8, 0);
    chk("mid_init_done_clr", done8, 0);
    sb.delete();
    tick();
    tick();
    rn8 = 1'b1;
    rel = cyc;
    exp_init8();
    wait_done8("rerun");
    drain("rerun");
    chk("rerun_busy_idle", busy8, 0);

    rn8 = 1'b0;
    tick();
    sel = 1'b1;
    tick();
    chk("n4_rst_ready", rdy4, 1);
    chk("n4_rst_rw", rw4, 0);
    chk("n4_rst_e", e4, 0);
    chk("n4_rst_db", db4, 0);
    rn4 = 1'b1;
    for (int k = 0; k < 8; k++)
      exp_byte(1'b0, init4[k], 1'b1, k < 4, k == 0, (k == 0) ? PON + 1 + S : -1);
    d4 = 8'hA5;
    v4 = 1'b1;
    exp_byte(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, -1);
    tick();
    v4 = 1'b0;
    for (int k = 0; k < 500 && !done4; k++) tick();
    chk("n4_init_done", done4, 1);
    drain("n4");
    chk("n4_overflow", ovf4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
